// File: rtl/audio_mixer.sv
// PSG + STE DMA audio mixer: fractional-rate sample clock, two-stage mix pipeline,
// master attenuation and saturation to 16-bit signed output words.
module audio_mixer #(
    parameter int CLK_HZ = 32000000,
    parameter int RATE   = 48000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         psg_a,
    input  logic [7:0]         psg_b,
    input  logic [7:0]         psg_c,
    input  logic               dma_valid,
    input  logic signed [7:0]  dma_l,
    input  logic signed [7:0]  dma_r,
    input  logic               dma_en,
    input  logic               mute,
    input  logic [3:0]         volume,
    output logic signed [15:0] audio_l,
    output logic signed [15:0] audio_r,
    output logic               clk_audio,
    output logic               sample_stb
);

    localparam int ACC_W = $clog2(CLK_HZ) + 1;
    localparam logic [ACC_W-1:0] STEP    = ACC_W'(2 * RATE);
    localparam logic [ACC_W-1:0] CLK_LIM = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic               clk_audio_q, clk_audio_d;
    logic               tick, capture;
    logic signed [7:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [9:0]         psg_sum;
    logic               s1_valid_q, s1_valid_d;
    logic signed [10:0] p_q, p_d;
    logic signed [7:0]  dl_q, dl_d, dr_q, dr_d;
    logic               mute_q, mute_d;
    logic [3:0]         vol_q, vol_d;
    logic signed [17:0] p_ext, dl_ext, dr_ext, mix_l, mix_r, sh_l, sh_r;
    logic signed [15:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic               stb_q, stb_d;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7fff;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    always_comb begin
        // Accumulator never exceeds CLK_HZ + 2*RATE, which fits in ACC_W bits.
        acc_sum     = acc_q + STEP;
        tick        = (acc_sum >= CLK_LIM);
        acc_d       = tick ? (acc_sum - CLK_LIM) : acc_sum;
        clk_audio_d = clk_audio_q ^ tick;
        capture     = tick & clk_audio_q;

        hold_l_d = dma_valid ? dma_l : hold_l_q;
        hold_r_d = dma_valid ? dma_r : hold_r_q;

        psg_sum    = {2'b00, psg_a} + {2'b00, psg_b} + {2'b00, psg_c};
        s1_valid_d = capture;
        p_d        = p_q;
        dl_d       = dl_q;
        dr_d       = dr_q;
        mute_d     = mute_q;
        vol_d      = vol_q;
        // The hold registers are read before this cycle's dma_valid lands in them.
        if (capture) begin
            p_d    = {1'b0, psg_sum} - 11'sd384;
            dl_d   = dma_en ? hold_l_q : 8'sd0;
            dr_d   = dma_en ? hold_r_q : 8'sd0;
            mute_d = mute;
            vol_d  = volume;
        end

        p_ext  = {{7{p_q[10]}}, p_q};
        dl_ext = {{10{dl_q[7]}}, dl_q};
        dr_ext = {{10{dr_q[7]}}, dr_q};
        mix_l  = (p_ext <<< 6) + (dl_ext <<< 7);
        mix_r  = (p_ext <<< 6) + (dr_ext <<< 7);
        sh_l   = mix_l >>> vol_q;
        sh_r   = mix_r >>> vol_q;

        stb_d     = s1_valid_q;
        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        if (s1_valid_q) begin
            audio_l_d = mute_q ? 16'sd0 : sat16(sh_l);
            audio_r_d = mute_q ? 16'sd0 : sat16(sh_r);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q       <= '0;
            clk_audio_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            s1_valid_q  <= 1'b0;
            p_q         <= '0;
            dl_q        <= '0;
            dr_q        <= '0;
            mute_q      <= 1'b0;
            vol_q       <= '0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
            stb_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            clk_audio_q <= clk_audio_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            s1_valid_q  <= s1_valid_d;
            p_q         <= p_d;
            dl_q        <= dl_d;
            dr_q        <= dr_d;
            mute_q      <= mute_d;
            vol_q       <= vol_d;
            audio_l_q   <= audio_l_d;
            audio_r_q   <= audio_r_d;
            stb_q       <= stb_d;
        end
    end

    assign audio_l    = audio_l_q;
    assign audio_r    = audio_r_q;
    assign clk_audio  = clk_audio_q;
    assign sample_stb = stb_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer: rate timing, mix/saturation/attenuation table,
// DMA capture-cycle boundary and mid-pipeline reset.
module tb_audio_mixer;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [7:0]         psg_a = 8'd128, psg_b = 8'd128, psg_c = 8'd128;
    logic               dma_valid = 1'b0;
    logic signed [7:0]  dma_l = 8'sd0, dma_r = 8'sd0;
    logic               dma_en = 1'b1;
    logic               mute = 1'b0;
    logic [3:0]         volume = 4'd0;
    logic signed [15:0] audio_l, audio_r;
    logic               clk_audio, sample_stb;

    audio_mixer dut (
        .clk(clk), .resetn(resetn),
        .psg_a(psg_a), .psg_b(psg_b), .psg_c(psg_c),
        .dma_valid(dma_valid), .dma_l(dma_l), .dma_r(dma_r),
        .dma_en(dma_en), .mute(mute), .volume(volume),
        .audio_l(audio_l), .audio_r(audio_r),
        .clk_audio(clk_audio), .sample_stb(sample_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]        a, b, c;
        logic signed [7:0] dl, dr;
        logic              en, mu;
        logic [3:0]        vol;
        int                exp_l, exp_r;
    } vec_t;

    vec_t vecs[9];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, stb_cnt = 0, tog_cnt = 0, first_tog = 0, first_stb = 0, hold_err = 0;
    logic ca_prev = 1'b0;
    logic signed [15:0] last_l = 0, last_r = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sample_stb) begin
            stb_cnt++;
            if (first_stb == 0) first_stb = cyc;
        end
        if (clk_audio != ca_prev) begin
            tog_cnt++;
            if (first_tog == 0) first_tog = cyc;
        end
        ca_prev = clk_audio;
        if (resetn && !sample_stb && (audio_l != last_l || audio_r != last_r)) hold_err++;
        last_l = audio_l;
        last_r = audio_r;
    endtask

    task automatic clear_counts();
        cyc = 0; stb_cnt = 0; tog_cnt = 0; first_tog = 0; first_stb = 0;
        ca_prev = clk_audio;
        last_l = audio_l;
        last_r = audio_r;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        clear_counts();
    endtask

    task automatic wait_stb(input string name);
        int n;
        n = 0;
        while (!sample_stb && n < 1500) begin
            step();
            n++;
        end
        if (!sample_stb) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int exp_stb, exp_tog, t;

        vecs[0] = '{8'd128, 8'd128, 8'd128,  8'sd64,  -8'sd64, 1'b1, 1'b0, 4'd0,   8192,  -8192};
        vecs[1] = '{8'd128, 8'd128, 8'd128,  8'sd64,  -8'sd64, 1'b1, 1'b0, 4'd2,   2048,  -2048};
        vecs[2] = '{8'd255, 8'd255, 8'd255,  8'sd127,  8'sd127, 1'b1, 1'b0, 4'd0,  32767,  32767};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   -8'sd128, -8'sd128, 1'b1, 1'b0, 4'd0, -32768, -32768};
        vecs[4] = '{8'd128, 8'd128, 8'd128,  8'sd64,  -8'sd64, 1'b1, 1'b1, 4'd0,      0,      0};
        vecs[5] = '{8'd200, 8'd100, 8'd50,   8'sd64,  -8'sd64, 1'b0, 1'b0, 4'd0,  -2176,  -2176};
        vecs[6] = '{8'd255, 8'd255, 8'd255, -8'sd128,  8'sd127, 1'b1, 1'b0, 4'd4,    500,   2540};
        vecs[7] = '{8'd0,   8'd0,   8'd0,   -8'sd128,  8'sd127, 1'b1, 1'b0, 4'd1, -20480,  -4160};
        vecs[8] = '{8'd0,   8'd0,   8'd0,   -8'sd128, -8'sd128, 1'b1, 1'b0, 4'd15,    -2,     -2};

        // Reset state
        do_reset();
        chk("rst_audio_l", int'(audio_l), 0);
        chk("rst_audio_r", int'(audio_r), 0);
        chk("rst_sample_stb", int'(sample_stb), 0);
        chk("rst_clk_audio", int'(clk_audio), 0);

        // Rate: ticks fall on cycle ceil(1000*k/3); captures on even k, strobe one cycle later
        while (cyc < 1000) step();
        chk("first_tick_cycle", first_tog, 334);
        chk("toggles_1000", tog_cnt, 3);
        chk("stb_1000", stb_cnt, 1);
        chk("first_stb_cycle", first_stb, 668);
        while (cyc < 20000) step();
        exp_stb = 0;
        exp_tog = 0;
        for (int k = 1; k <= 70; k++) begin
            t = (1000 * k + 2) / 3;
            if (t <= 20000) exp_tog++;
            if ((k % 2 == 0) && (t + 1 <= 20000)) exp_stb++;
        end
        chk("toggles_20000", tog_cnt, exp_tog);
        chk("stb_20000", stb_cnt, exp_stb);

        // Mix table: load DMA right after a strobe, check at the next strobe
        wait_stb("sync");
        for (int i = 0; i < 9; i++) begin
            psg_a = vecs[i].a; psg_b = vecs[i].b; psg_c = vecs[i].c;
            dma_l = vecs[i].dl; dma_r = vecs[i].dr;
            dma_en = vecs[i].en; mute = vecs[i].mu; volume = vecs[i].vol;
            dma_valid = 1'b1;
            step();
            dma_valid = 1'b0;
            wait_stb($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_l", i), int'(audio_l), vecs[i].exp_l);
            chk($sformatf("vec%0d_r", i), int'(audio_r), vecs[i].exp_r);
        end
        mute = 1'b0; volume = 4'd0; dma_en = 1'b1;

        // DMA strobe in the capture cycle (667) uses the old hold value
        do_reset();
        psg_a = 8'd128; psg_b = 8'd128; psg_c = 8'd128;
        dma_l = 8'sd10; dma_r = -8'sd10; dma_valid = 1'b1;
        step();
        dma_valid = 1'b0;
        while (cyc < 666) step();
        dma_l = 8'sd50; dma_r = -8'sd50; dma_valid = 1'b1;
        step();
        dma_valid = 1'b0;
        psg_a = 8'd0; psg_b = 8'd0; psg_c = 8'd0;
        step();
        chk("bnd_stb_at_668", int'(sample_stb), 1);
        chk("bnd_old_l", int'(audio_l), 1280);
        chk("bnd_old_r", int'(audio_r), -1280);
        while (cyc < 1335) step();
        chk("bnd_stb_at_1335", int'(sample_stb), 1);
        chk("bnd_new_l", int'(audio_l), -18176);
        chk("bnd_new_r", int'(audio_r), -30976);

        // Reset for one cycle at C+1 of the capture at cycle 2000
        while (cyc < 2000) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("midrst_audio_l", int'(audio_l), 0);
        chk("midrst_audio_r", int'(audio_r), 0);
        clear_counts();
        step();
        chk("midrst_no_stb", int'(sample_stb), 0);
        while (cyc < 700) step();
        chk("midrst_first_tick", first_tog, 334);
        chk("midrst_stb_count", stb_cnt, 1);
        chk("midrst_first_stb", first_stb, 668);

        chk("hold_between_stb", hold_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
